bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3) that produces the packed 4-digit BCD word driving the seven-segment display stage's 16-bit digit input.
- Sits between CPU-side value selection (register/PC/ALU result) and the display driver.
- Converts one bit per clock, saturates out-of-range values, and holds the last result stable so the display never shows partial values.

---
 rtl/display_pkg.sv | 26 ++
 rtl/bcd_add3.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 120 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display value path.
// Contents:
//   state_t  - sequencing states of the binary-to-BCD converter
//   BCD_W    - bits per BCD digit
//   max_dec  - largest decimal value representable in a given digit count
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    // 10^digits - 1, evaluated at elaboration time for the saturation limit.
    function automatic logic [63:0] max_dec(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit correction step of the shift-and-add-3 algorithm.
// Ports:
//   d_i - BCD digit before the shift
//   d_o - digit plus 3 when d_i >= 5, otherwise d_i unchanged
module bcd_add3
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] d_i,
    output logic [BCD_W-1:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter feeding the seven-segment display stage.
// One input bit is consumed per clock; inputs above 10^DIGITS-1 saturate to
// all nines with OVF set. BCD_OUT/OVF update only when a conversion finishes,
// so the display never sees a partially converted value.
// Ports:
//   CLK     - system clock, rising edge
//   RST_N   - asynchronous active-low reset
//   START   - conversion request, accepted in IDLE or FIN
//   BIN_IN  - unsigned value, sampled only on accept
//   BUSY    - high while bits are being shifted
//   DONE    - one-cycle pulse when BCD_OUT/OVF have just been updated
//   OVF     - last accepted BIN_IN exceeded the decimal range
//   BCD_OUT - packed BCD result, digit 0 in [3:0]
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      START,
    input  logic [BIN_W-1:0]          BIN_IN,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      OVF,
    output logic [BCD_W*DIGITS-1:0]   BCD_OUT
);

    localparam int          SCR_W   = BCD_W * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_DEC = max_dec(DIGITS);

    state_t             state_q;
    logic [BIN_W-1:0]   bin_q;
    logic [SCR_W-1:0]   scratch_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_pend_q;
    logic [SCR_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_d;
    logic [BIN_W-1:0]   bin_d;
    logic               ovf_in;
    logic [BIN_W-1:0]   bin_clamped;

    // When MAX_DEC does not fit in BIN_W bits the compare can never be true,
    // so the truncated slice below is never selected.
    assign ovf_in      = 64'(BIN_IN) > MAX_DEC;
    assign bin_clamped = ovf_in ? MAX_DEC[BIN_W-1:0] : BIN_IN;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (scratch_q[g*BCD_W +: BCD_W]),
            .d_o (scratch_adj[g*BCD_W +: BCD_W])
        );
    end

    // Correct all digits first, then shift {scratch, bin} left by one.
    assign scratch_d = {scratch_adj[SCR_W-2:0], bin_q[BIN_W-1]};
    assign bin_d     = {bin_q[BIN_W-2:0], 1'b0};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    done_q <= 1'b0;
                    if (START) begin
                        bin_q      <= bin_clamped;
                        ovf_pend_q <= ovf_in;
                        scratch_q  <= '0;
                        cnt_q      <= CNT_W'(BIN_W);
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    bin_q     <= bin_d;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    // Last bit: publish the shifted value directly.
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= scratch_d;
                        ovf_q   <= ovf_pend_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign OVF     = ovf_q;
    assign BCD_OUT = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases plus random values
// compared against a decimal-digit reference model.
module tb_bin_to_bcd_seq;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [15:0] BIN_IN;
    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic [15:0] BCD_OUT;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_bcd;
    logic        exp_ovf;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .BIN_IN  (BIN_IN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .OVF     (OVF),
        .BCD_OUT (BCD_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: saturate, then split into decimal digits.
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        int unsigned c;
        logic [15:0] r;
        c = (v > 9999) ? 9999 : v;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(c % 10);
            c = c / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called at the first sample after an accept edge. Checks BUSY and held
    // outputs each cycle, then latency and DONE.
    task automatic wait_done(input string tag, input bit toggle);
        int n;
        n = 1;
        while (DONE !== 1'b1 && n < 40) begin
            chk({tag, "_busy"}, BUSY, 1);
            chk({tag, "_hold_bcd"}, BCD_OUT, exp_bcd);
            chk({tag, "_hold_ovf"}, OVF, exp_ovf);
            if (toggle) BIN_IN = 16'($urandom);
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 17);
        chk({tag, "_done"}, DONE, 1);
        chk({tag, "_busy_fin"}, BUSY, 0);
    endtask

    task automatic run_conv(input logic [15:0] v, input string tag, input bit toggle);
        START  = 1'b1;
        BIN_IN = v;
        tick();
        START = 1'b0;
        wait_done(tag, toggle);
        exp_bcd = ref_bcd(v);
        exp_ovf = (v > 16'd9999);
        chk({tag, "_bcd"}, BCD_OUT, exp_bcd);
        chk({tag, "_ovf"}, OVF, exp_ovf);
        tick();
        chk({tag, "_done_pulse"}, DONE, 0);
    endtask

    initial begin
        logic [15:0] rv;
        RST_N  = 1'b0;
        START  = 1'b0;
        BIN_IN = '0;
        exp_bcd = '0;
        exp_ovf = 1'b0;
        #2;
        chk("rst_bcd", BCD_OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_ovf", OVF, 0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        // Give BCD_OUT a nonzero value so the reset clear is observable.
        run_conv(16'd10000, "pre", 1'b0);

        // Reset during SHIFT cycle 7 of a 1234 conversion.
        START  = 1'b1;
        BIN_IN = 16'd1234;
        tick();
        START = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_busy", BUSY, 1);
        RST_N = 1'b0;
        #1;
        chk("arst_bcd", BCD_OUT, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_done", DONE, 0);
        chk("arst_ovf", OVF, 0);
        tick();
        tick();
        RST_N = 1'b1;
        exp_bcd = '0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("post_rst_done", DONE, 0);
            chk("post_rst_busy", BUSY, 0);
            tick();
        end
        run_conv(16'd5, "after_rst", 1'b0);

        run_conv(16'd1234, "v1234", 1'b0);

        run_conv(16'd9999, "v9999", 1'b0);
        run_conv(16'd10000, "v10000", 1'b0);
        run_conv(16'd65535, "v65535", 1'b0);
        run_conv(16'd7, "v7", 1'b0);

        run_conv(16'd0, "v0", 1'b0);
        run_conv(16'd9, "v9", 1'b0);
        run_conv(16'd10, "v10", 1'b0);
        run_conv(16'd99, "v99", 1'b0);
        run_conv(16'd100, "v100", 1'b0);
        run_conv(16'd5050, "v5050", 1'b0);

        // START held during SHIFT is ignored; START in FIN is accepted.
        START  = 1'b1;
        BIN_IN = 16'd1234;
        tick();
        BIN_IN = 16'd42;
        wait_done("b2b_first", 1'b0);
        exp_bcd = 16'h1234;
        exp_ovf = 1'b0;
        chk("b2b_first_bcd", BCD_OUT, exp_bcd);
        tick();
        START = 1'b0;
        wait_done("b2b_second", 1'b0);
        exp_bcd = ref_bcd(42);
        chk("b2b_second_bcd", BCD_OUT, 16'h0042);
        chk("b2b_second_ovf", OVF, 0);
        tick();
        chk("b2b_idle_done", DONE, 0);

        // BIN_IN changes after accept must not matter; idle must hold.
        run_conv(16'd3000, "v3000", 1'b1);
        for (int i = 0; i < 100; i++) begin
            BIN_IN = 16'($urandom);
            tick();
            chk("idle_bcd", BCD_OUT, 16'h3000);
            chk("idle_done", DONE, 0);
        end

        // Random values across the range, biased toward the saturation edge.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: rv = 16'($urandom);
                1: rv = 16'($urandom_range(0, 9999));
                default: rv = 16'($urandom_range(9990, 10010));
            endcase
            run_conv(rv, "rand", 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
